// File: rtl/vpu_sram_rd_arb.sv
// Round-robin arbiter that shares one fixed-latency SRAM read port between REQ_CNT requesters.
// Optional macro VPU_RDARB_OUTREG_EN registers the response outputs (adds one cycle of latency).
module vpu_sram_rd_arb #(
    parameter int REQ_CNT     = 3,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 256,
    parameter int SRAM_RD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REQ_CNT-1:0]        req_valid_i,
    input  logic [REQ_CNT*ADDR_W-1:0] req_addr_i,
    output logic [REQ_CNT-1:0]        req_ready_o,
    input  logic                      flush_i,
    output logic                      sram_rden_o,
    output logic [ADDR_W-1:0]         sram_raddr_o,
    input  logic [DATA_W-1:0]         sram_rdata_i,
    output logic [REQ_CNT-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      busy_o
);

    localparam int PTR_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    logic [PTR_W-1:0]                   ptr_r;
    logic [PTR_W-1:0]                   ptr_nxt_s;
    logic [PTR_W-1:0]                   grant_id_s;
    logic [PTR_W-1:0]                   idx_s;
    logic                               grant_any_s;
    logic [REQ_CNT-1:0]                 grant_oh_s;
    logic [SRAM_RD_LAT-1:0]             tag_valid_r;
    logic [SRAM_RD_LAT-1:0][PTR_W-1:0]  tag_id_r;
    logic                               rsp_any_s;
    logic [REQ_CNT-1:0]                 rsp_oh_s;
    logic [DATA_W-1:0]                  rsp_data_s;

    // Round-robin search from ptr_r upward; requests are masked while flushing or in reset.
    always_comb begin
        grant_oh_s  = {REQ_CNT{1'b0}};
        grant_id_s  = {PTR_W{1'b0}};
        grant_any_s = 1'b0;
        idx_s       = {PTR_W{1'b0}};
        for (int i = 0; i < REQ_CNT; i++) begin
            idx_s = PTR_W'((int'(ptr_r) + i) % REQ_CNT);
            if (!grant_any_s && req_valid_i[idx_s] && !flush_i && rst_n) begin
                grant_any_s       = 1'b1;
                grant_id_s        = idx_s;
                grant_oh_s[idx_s] = 1'b1;
            end else begin
                grant_oh_s = grant_oh_s;
            end
        end
    end

    // Pointer advances to the requester after the one just granted, wrapping at REQ_CNT-1.
    always_comb begin
        if (grant_id_s == PTR_W'(REQ_CNT - 1)) begin
            ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            ptr_nxt_s = grant_id_s + PTR_W'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (flush_i) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (grant_any_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Tag pipeline tracks which requester owns each read in flight; it never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= {SRAM_RD_LAT{1'b0}};
            tag_id_r    <= '0;
        end else if (flush_i) begin
            tag_valid_r <= {SRAM_RD_LAT{1'b0}};
            tag_id_r    <= '0;
        end else begin
            tag_valid_r[0] <= grant_any_s;
            tag_id_r[0]    <= grant_id_s;
            for (int i = 1; i < SRAM_RD_LAT; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_id_r[i]    <= tag_id_r[i-1];
            end
        end
    end

    // Decode the pipeline tail into a one-hot response; a flush suppresses returning data.
    always_comb begin
        rsp_oh_s   = {REQ_CNT{1'b0}};
        rsp_any_s  = tag_valid_r[SRAM_RD_LAT-1] && !flush_i;
        rsp_data_s = {DATA_W{1'b0}};
        if (rsp_any_s) begin
            rsp_oh_s[tag_id_r[SRAM_RD_LAT-1]] = 1'b1;
            rsp_data_s                        = sram_rdata_i;
        end else begin
            rsp_data_s = {DATA_W{1'b0}};
        end
    end

    assign req_ready_o  = grant_oh_s;
    assign sram_rden_o  = grant_any_s;
    assign sram_raddr_o = grant_any_s ? req_addr_i[int'(grant_id_s)*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};

`ifdef VPU_RDARB_OUTREG_EN
    logic [REQ_CNT-1:0] out_valid_r;
    logic [DATA_W-1:0]  out_data_r;

    // Response output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= {REQ_CNT{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
        end else if (flush_i) begin
            out_valid_r <= {REQ_CNT{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            out_valid_r <= rsp_oh_s;
            out_data_r  <= rsp_data_s;
        end
    end

    assign rsp_valid_o = out_valid_r & {REQ_CNT{~flush_i}};
    assign rsp_data_o  = out_data_r;
    assign busy_o      = (|tag_valid_r) | (|out_valid_r);
`else
    assign rsp_valid_o = rsp_oh_s;
    assign rsp_data_o  = rsp_data_s;
    assign busy_o      = |tag_valid_r;
`endif

endmodule

// File: tb/tb_vpu_sram_rd_arb.sv
// Self-checking bench for vpu_sram_rd_arb: table-driven grant vectors, a response scoreboard
// fed from the expected grants, and hand-written flush / reset / idle sequences.
module tb_vpu_sram_rd_arb;

    localparam int REQ_CNT = 3;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 256;
    localparam int LAT     = 2;
`ifdef VPU_RDARB_OUTREG_EN
    localparam int RSP_LAT = LAT + 1;
`else
    localparam int RSP_LAT = LAT;
`endif

    logic                      clk;
    logic                      rst_n;
    logic [REQ_CNT-1:0]        req_valid_i;
    logic [REQ_CNT*ADDR_W-1:0] req_addr_i;
    logic [REQ_CNT-1:0]        req_ready_o;
    logic                      flush_i;
    logic                      sram_rden_o;
    logic [ADDR_W-1:0]         sram_raddr_o;
    logic [DATA_W-1:0]         sram_rdata_i;
    logic [REQ_CNT-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]         rsp_data_o;
    logic                      busy_o;

    vpu_sram_rd_arb #(
        .REQ_CNT(REQ_CNT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .req_ready_o(req_ready_o), .flush_i(flush_i), .sram_rden_o(sram_rden_o),
        .sram_raddr_o(sram_raddr_o), .sram_rdata_i(sram_rdata_i), .rsp_valid_o(rsp_valid_o),
        .rsp_data_o(rsp_data_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {(DATA_W/32){32'hA5A5_0000 | {22'h0, a}}};
    endfunction

    // SRAM model: fixed two-cycle read latency, junk data when not reading.
    logic [DATA_W-1:0] s1_r, s2_r;
    always @(posedge clk) begin
        s1_r <= sram_rden_o ? mem_word(sram_raddr_o) : {(DATA_W/32){32'hDEAD_BEEF}};
        s2_r <= s1_r;
    end
    assign sram_rdata_i = s2_r;

    typedef struct {
        int                id;
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [2:0] v;
        logic       fl;
        logic [2:0] rdy;
    } vec_t;
    vec_t tbl[13];

    logic [ADDR_W-1:0] addr_tab[REQ_CNT];
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational/registered outputs 1ns later.
    task automatic step(input logic [2:0] v, input logic fl, input logic [2:0] exp_rdy);
        logic [2:0]        exp_rsp;
        logic [DATA_W-1:0] exp_data;
        logic              exp_busy;
        exp_t              e;
        @(negedge clk);
        req_valid_i = v;
        flush_i     = fl;
        req_addr_i  = {addr_tab[2], addr_tab[1], addr_tab[0]};
        #1;
        exp_rsp  = 3'b000;
        exp_data = {DATA_W{1'b0}};
        exp_busy = (sb_q.size() != 0);
        if (!fl && sb_q.size() != 0 && sb_q[0].due == cyc) begin
            exp_rsp[sb_q[0].id] = 1'b1;
            exp_data            = sb_q[0].data;
        end
        chk("req_ready", DATA_W'(req_ready_o), DATA_W'(exp_rdy));
        chk("sram_rden", DATA_W'(sram_rden_o), DATA_W'(|exp_rdy));
        for (int k = 0; k < REQ_CNT; k++) begin
            if (exp_rdy[k]) chk("sram_raddr", DATA_W'(sram_raddr_o), DATA_W'(addr_tab[k]));
        end
        chk("rsp_valid", DATA_W'(rsp_valid_o), DATA_W'(exp_rsp));
        chk("rsp_data", rsp_data_o, exp_data);
        chk("busy", DATA_W'(busy_o), DATA_W'(exp_busy));
        if (fl) begin
            sb_q.delete();
        end else begin
            if (sb_q.size() != 0 && sb_q[0].due == cyc) void'(sb_q.pop_front());
            for (int k = 0; k < REQ_CNT; k++) begin
                if (exp_rdy[k]) begin
                    e.id = k; e.due = cyc + RSP_LAT; e.data = mem_word(addr_tab[k]);
                    sb_q.push_back(e);
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 1'b0, 3'b000);
    endtask

    initial begin
        // Expected grants assume the pointer starts at 0 out of reset.
        tbl[0]  = '{3'b111, 1'b0, 3'b001};
        tbl[1]  = '{3'b111, 1'b0, 3'b010};
        tbl[2]  = '{3'b111, 1'b0, 3'b100};
        tbl[3]  = '{3'b111, 1'b0, 3'b001};
        tbl[4]  = '{3'b000, 1'b0, 3'b000};
        tbl[5]  = '{3'b101, 1'b0, 3'b100};
        tbl[6]  = '{3'b011, 1'b0, 3'b001};
        tbl[7]  = '{3'b011, 1'b0, 3'b010};
        tbl[8]  = '{3'b011, 1'b0, 3'b001};
        tbl[9]  = '{3'b100, 1'b0, 3'b100};
        tbl[10] = '{3'b000, 1'b0, 3'b000};
        tbl[11] = '{3'b000, 1'b0, 3'b000};
        tbl[12] = '{3'b000, 1'b0, 3'b000};
        addr_tab[0] = 10'h010;
        addr_tab[1] = 10'h020;
        addr_tab[2] = 10'h030;

        rst_n       = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = 3'b111;
        req_addr_i  = {addr_tab[2], addr_tab[1], addr_tab[0]};
        @(negedge clk);
        #1;
        chk("rst_ready", DATA_W'(req_ready_o), DATA_W'(3'b000));
        chk("rst_rden", DATA_W'(sram_rden_o), DATA_W'(1'b0));
        chk("rst_rsp_valid", DATA_W'(rsp_valid_o), DATA_W'(3'b000));
        chk("rst_rsp_data", rsp_data_o, {DATA_W{1'b0}});
        chk("rst_busy", DATA_W'(busy_o), DATA_W'(1'b0));
        @(negedge clk);
        req_valid_i = 3'b000;
        rst_n       = 1'b1;

        for (int i = 0; i < 13; i++) step(tbl[i].v, tbl[i].fl, tbl[i].rdy);

        // Lone request from the top requester wraps the pointer to 0.
        step(3'b100, 1'b0, 3'b100);
        step(3'b010, 1'b0, 3'b010);
        idle(3);

        // Max address from requester 1 returns exactly RSP_LAT cycles later.
        addr_tab[1] = 10'h3FF;
        step(3'b010, 1'b0, 3'b010);
        for (int i = 0; i < RSP_LAT; i++) step(3'b000, 1'b0, 3'b000);
        chk("maxaddr_rsp_valid", DATA_W'(rsp_valid_o), DATA_W'(3'b010));
        chk("maxaddr_rsp_top", DATA_W'(rsp_data_o[DATA_W-1 -: 8]), DATA_W'(8'hA5));
        idle(2);

        // Flush with two reads in flight; pointer now 2.
        step(3'b001, 1'b0, 3'b001);
        step(3'b010, 1'b0, 3'b010);
        step(3'b001, 1'b1, 3'b000);
        step(3'b001, 1'b0, 3'b001);
        idle(4);

        // Asynchronous reset with reads in flight; pointer now 1.
        step(3'b111, 1'b0, 3'b010);
        step(3'b111, 1'b0, 3'b100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", DATA_W'(req_ready_o), DATA_W'(3'b000));
        chk("arst_rden", DATA_W'(sram_rden_o), DATA_W'(1'b0));
        chk("arst_rsp_valid", DATA_W'(rsp_valid_o), DATA_W'(3'b000));
        chk("arst_rsp_data", rsp_data_o, {DATA_W{1'b0}});
        chk("arst_busy", DATA_W'(busy_o), DATA_W'(1'b0));
        sb_q.delete();
        cyc++;
        @(negedge clk);
        req_valid_i = 3'b000;
        rst_n       = 1'b1;
        cyc++;
        idle(4);
        step(3'b111, 1'b0, 3'b001);

        // Ten idle cycles leave the pointer at 1.
        idle(10);
        step(3'b111, 1'b0, 3'b010);
        idle(3);

        // Flush on an idle block only resets the pointer (2 -> 0).
        step(3'b000, 1'b1, 3'b000);
        step(3'b110, 1'b0, 3'b010);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
